// File: rtl/ultrasonic_pkg.sv
// Shared types and constants for the multi-channel ultrasonic ranger:
// FSM states, the echo-time-per-centimetre constant and seven-segment codes.
package ultrasonic_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_TRIG,
        ST_WAIT_RISE,
        ST_MEASURE,
        ST_HOLDOFF
    } state_t;

    // Round-trip echo time per centimetre of range, in microseconds.
    localparam int US_PER_CM = 58;

    // Active-high segments, bit order gfedcba; element index is the decimal digit.
    localparam logic [9:0][6:0] SEG_DIGITS = {
        7'b1101111, 7'b1111111, 7'b0000111, 7'b1111101, 7'b1101101,
        7'b1100110, 7'b1001111, 7'b1011011, 7'b0000110, 7'b0111111
    };
    localparam logic [6:0] SEG_DASH  = 7'b1000000;
    localparam logic [6:0] SEG_BLANK = 7'b0000000;

    // Increment a three-digit packed BCD value {hundreds, tens, ones}.
    function automatic logic [11:0] bcd3_inc(input logic [11:0] v);
        logic [11:0] r;
        r = v;
        if (r[3:0] == 4'd9) begin
            r[3:0] = 4'd0;
            if (r[7:4] == 4'd9) begin
                r[7:4]  = 4'd0;
                r[11:8] = r[11:8] + 4'd1;
            end else begin
                r[7:4] = r[7:4] + 4'd1;
            end
        end else begin
            r[3:0] = r[3:0] + 4'd1;
        end
        return r;
    endfunction

endpackage

// File: rtl/seg7_decode.sv
// One seven-segment digit: BCD to active-high gfedcba code, with dash and blank overrides.
module seg7_decode
    import ultrasonic_pkg::*;
(
    input  logic [3:0] bcd,
    input  logic       blank,
    input  logic       dash,
    output logic [6:0] seg
);

    // NOTE: seg gets a default before any branch so no path leaves it unassigned (no latch).
    always_comb begin
        seg = SEG_BLANK;
        if (dash) begin
            seg = SEG_DASH;
        end else if (!blank && bcd <= 4'd9) begin
            seg = SEG_DIGITS[bcd];
        end
    end

endmodule

// File: rtl/ultrasonic_ranger_mc.sv
// Multi-channel ultrasonic ranger: round-robin trigger/measure FSM, per-channel BCD
// result store, and a three-digit seven-segment readout of the selected channel.
module ultrasonic_ranger_mc
    import ultrasonic_pkg::*;
#(
    parameter int CLK_HZ     = 50_000_000,
    parameter int N_CH       = 2,
    parameter int TRIG_US    = 10,
    parameter int TIMEOUT_US = 38000,
    parameter int HOLDOFF_US = 60000,
    parameter int MAX_CM     = 400
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            on_off,
    input  logic [N_CH-1:0] echo,
    input  logic [2:0]      disp_sel,
    output logic [N_CH-1:0] trig,
    output logic            dist_valid,
    output logic [2:0]      dist_ch,
    output logic [8:0]      dist_cm,
    output logic            dist_timeout,
    output logic            busy,
    output logic [6:0]      ones,
    output logic [6:0]      tens,
    output logic [6:0]      hundreds
);

    localparam int US_TICKS = CLK_HZ / 1_000_000;
    localparam int DIV_W    = $clog2(US_TICKS);
    localparam int US_MAX   = (TIMEOUT_US > HOLDOFF_US)
                              ? ((TIMEOUT_US > TRIG_US) ? TIMEOUT_US : TRIG_US)
                              : ((HOLDOFF_US > TRIG_US) ? HOLDOFF_US : TRIG_US);
    localparam int US_W     = $clog2(US_MAX + 1);
    localparam int CH_W     = (N_CH > 1) ? $clog2(N_CH) : 1;

    state_t            state, next_state;
    logic [N_CH-1:0]   echo_meta, echo_s;
    logic [DIV_W-1:0]  div_cnt;
    logic [US_W-1:0]   us_cnt;
    logic [5:0]        sub_cnt;
    logic [8:0]        cm_cnt;
    logic [11:0]       bcd_cnt;
    logic [CH_W-1:0]   ch, sel;
    logic              tick, echo_ch, done, done_to;
    logic [11:0]       ent_bcd [N_CH];
    logic              ent_to  [N_CH];
    logic [11:0]       disp_bcd;

    always_ff @(posedge clk) begin
        if (rst) begin
            echo_meta <= '0;
            echo_s    <= '0;
        end else begin
            echo_meta <= echo;
            echo_s    <= echo_meta;
        end
    end

    assign tick    = (div_cnt == DIV_W'(US_TICKS - 1));
    assign echo_ch = echo_s[ch];

    always_comb begin
        next_state = state;
        done       = 1'b0;
        done_to    = 1'b0;
        case (state)
            ST_IDLE:      if (on_off) next_state = ST_TRIG;
            ST_TRIG:      if (tick && us_cnt == US_W'(TRIG_US - 1)) next_state = ST_WAIT_RISE;
            ST_WAIT_RISE: begin
                if (echo_ch) begin
                    next_state = ST_MEASURE;
                end else if (tick && us_cnt == US_W'(TIMEOUT_US - 1)) begin
                    next_state = ST_HOLDOFF;
                    done       = 1'b1;
                    done_to    = 1'b1;
                end
            end
            ST_MEASURE: begin
                if (!echo_ch) begin
                    next_state = ST_HOLDOFF;
                    done       = 1'b1;
                end else if (tick && sub_cnt == 6'(US_PER_CM - 1) && cm_cnt == 9'(MAX_CM - 1)) begin
                    next_state = ST_HOLDOFF;
                    done       = 1'b1;
                    done_to    = 1'b1;
                end
            end
            ST_HOLDOFF:   if (tick && us_cnt == US_W'(HOLDOFF_US - 1)) next_state = ST_IDLE;
            default:      next_state = ST_IDLE;
        endcase
    end

    // The echo-detect cycle spent in WAIT_RISE already counts toward the first microsecond,
    // so MEASURE starts its divider one cycle in.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_IDLE;
            div_cnt      <= '0;
            us_cnt       <= '0;
            sub_cnt      <= '0;
            cm_cnt       <= '0;
            bcd_cnt      <= '0;
            ch           <= '0;
            dist_valid   <= 1'b0;
            dist_ch      <= '0;
            dist_cm      <= '0;
            dist_timeout <= 1'b0;
        end else begin
            state      <= next_state;
            dist_valid <= done;
            if (next_state != state) begin
                div_cnt <= (next_state == ST_MEASURE) ? DIV_W'(1) : '0;
                us_cnt  <= '0;
            end else begin
                div_cnt <= tick ? '0 : div_cnt + 1'b1;
                if (tick) us_cnt <= us_cnt + 1'b1;
            end
            if (state == ST_WAIT_RISE) begin
                sub_cnt <= '0;
                cm_cnt  <= '0;
                bcd_cnt <= '0;
            end else if (state == ST_MEASURE && tick && echo_ch) begin
                if (sub_cnt == 6'(US_PER_CM - 1)) begin
                    sub_cnt <= '0;
                    cm_cnt  <= cm_cnt + 1'b1;
                    bcd_cnt <= bcd3_inc(bcd_cnt);
                end else begin
                    sub_cnt <= sub_cnt + 1'b1;
                end
            end
            if (done) begin
                dist_ch      <= 3'(ch);
                dist_cm      <= done_to ? 9'(MAX_CM) : cm_cnt;
                dist_timeout <= done_to;
            end
            if (state == ST_HOLDOFF && next_state == ST_IDLE) begin
                ch <= (ch == CH_W'(N_CH - 1)) ? '0 : ch + 1'b1;
            end
        end
    end

    // NOTE: the result store is reset entry by entry because the display must read 000 after rst.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N_CH; i++) begin
                ent_bcd[i] <= '0;
                ent_to[i]  <= 1'b0;
            end
        end else if (done) begin
            ent_bcd[ch] <= bcd_cnt;
            ent_to[ch]  <= done_to;
        end
    end

    always_comb begin
        trig = '0;
        if (state == ST_TRIG) trig[ch] = 1'b1;
    end

    assign busy     = (state != ST_IDLE);
    assign sel      = (int'(disp_sel) < N_CH) ? CH_W'(disp_sel) : '0;
    assign disp_bcd = ent_bcd[sel];

    seg7_decode u_ones (.bcd(disp_bcd[3:0]),  .blank(1'b0), .dash(ent_to[sel]), .seg(ones));
    seg7_decode u_tens (.bcd(disp_bcd[7:4]),  .blank(1'b0), .dash(ent_to[sel]), .seg(tens));
    seg7_decode u_hund (.bcd(disp_bcd[11:8]), .blank(1'b0), .dash(ent_to[sel]), .seg(hundreds));

endmodule

// File: tb/tb_ultrasonic_ranger_mc.sv
// Scoreboard bench for ultrasonic_ranger_mc: stimulus queues expected results, a monitor
// compares each dist_valid strobe; timing, display and reset behaviour are checked directly.
module tb_ultrasonic_ranger_mc;

    logic       clk;
    logic       rst;
    logic       on_off;
    logic [1:0] echo;
    logic [2:0] disp_sel;
    logic [1:0] trig;
    logic       dist_valid;
    logic [2:0] dist_ch;
    logic [8:0] dist_cm;
    logic       dist_timeout;
    logic       busy;
    logic [6:0] ones, tens, hundreds;

    localparam logic [6:0] S0   = 7'b0111111;
    localparam logic [6:0] S1   = 7'b0000110;
    localparam logic [6:0] S7   = 7'b0000111;
    localparam logic [6:0] DASH = 7'b1000000;

    typedef struct packed {
        logic [2:0] ch;
        logic [8:0] cm;
        logic       to;
    } res_t;

    res_t exp_q[$];
    res_t mon_e;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;

    ultrasonic_ranger_mc #(
        .CLK_HZ    (4_000_000),
        .N_CH      (2),
        .TRIG_US   (10),
        .TIMEOUT_US(500),
        .HOLDOFF_US(100),
        .MAX_CM    (20)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .on_off      (on_off),
        .echo        (echo),
        .disp_sel    (disp_sel),
        .trig        (trig),
        .dist_valid  (dist_valid),
        .dist_ch     (dist_ch),
        .dist_cm     (dist_cm),
        .dist_timeout(dist_timeout),
        .busy        (busy),
        .ones        (ones),
        .tens        (tens),
        .hundreds    (hundreds)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #900_000;
        $display("FAIL watchdog: simulation still running at cycle %0d, limit 90000", cyc);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_tests++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic expect_res(input int c, input int cm, input bit to);
        exp_q.push_back(res_t'({3'(c), 9'(cm), to}));
    endtask

    // Scoreboard monitor: every result strobe must match the oldest queued expectation.
    always @(negedge clk) begin
        if (!rst && dist_valid) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_result: ch=%0d cm=%0d to=%0d with nothing expected",
                         dist_ch, dist_cm, dist_timeout);
            end else begin
                mon_e = exp_q.pop_front();
                check("result_ch", 32'(dist_ch), 32'(mon_e.ch));
                check("result_cm", 32'(dist_cm), 32'(mon_e.cm));
                check("result_timeout", 32'(dist_timeout), 32'(mon_e.to));
            end
        end
    end

    task automatic check_disp(input string name, input logic [2:0] sel,
                              input logic [6:0] h, input logic [6:0] t, input logic [6:0] o);
        disp_sel = sel;
        #1;
        check({name, "_hundreds"}, 32'(hundreds), 32'(h));
        check({name, "_tens"}, 32'(tens), 32'(t));
        check({name, "_ones"}, 32'(ones), 32'(o));
    endtask

    task automatic wait_trig(input logic chan, input int limit, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < limit && !seen; i++) begin
            @(negedge clk);
            if (trig[chan]) seen = 1'b1;
        end
        check("trig_seen", 32'(seen), 32'd1);
        if (seen) check("trig_onehot", 32'(trig), 32'(2'b01 << chan));
    endtask

    task automatic wait_valid(input string name, input int limit, output int at);
        bit ok;
        ok = 1'b0;
        at = 0;
        for (int i = 0; i < limit && !ok; i++) begin
            @(negedge clk);
            if (dist_valid) begin
                ok = 1'b1;
                at = cyc;
            end
        end
        check({name, "_valid_seen"}, 32'(ok), 32'd1);
    endtask

    // drop_mode: 0 keep on_off, 1 drop at trigger rise, 2 drop halfway through the echo.
    task automatic run_ping(input logic chan, input int echo_len, input int drop_mode,
                            output int t_fall);
        bit seen;
        int w;
        t_fall = 0;
        wait_trig(chan, 3000, seen);
        if (!seen) return;
        if (drop_mode == 1) on_off = 1'b0;
        w = 1;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (!trig[chan]) break;
            w++;
        end
        check("trig_width", 32'(w), 32'd40);
        t_fall = cyc;
        if (echo_len > 0) begin
            repeat (40) @(negedge clk);
            echo[chan] = 1'b1;
            if (drop_mode == 2) begin
                repeat (echo_len / 2) @(negedge clk);
                on_off = 1'b0;
                repeat (echo_len - echo_len / 2) @(negedge clk);
            end else begin
                repeat (echo_len) @(negedge clk);
            end
            echo[chan] = 1'b0;
        end
    endtask

    initial begin
        int  tf, at;
        bit  seen;

        rst      = 1'b1;
        on_off   = 1'b0;
        echo     = '0;
        disp_sel = '0;
        repeat (3) @(negedge clk);
        check("rst_trig", 32'(trig), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_valid", 32'(dist_valid), 32'd0);
        check("rst_cm", 32'(dist_cm), 32'd0);
        check_disp("rst_disp", 3'd0, S0, S0, S0);
        rst    = 1'b0;
        on_off = 1'b1;

        // ch0: 1160 us echo reaches the 20 cm ceiling while still high.
        expect_res(0, 20, 1'b1);
        run_ping(1'b0, 4640, 0, tf);
        wait_valid("p1", 200, at);
        check_disp("p1_disp", 3'd0, DASH, DASH, DASH);

        // ch1: no echo, timeout after 500 us.
        expect_res(1, 20, 1'b1);
        run_ping(1'b1, 0, 0, tf);
        wait_valid("p2", 3000, at);
        check("p2_timeout_latency", 32'(at - tf), 32'd2000);
        check_disp("p2_disp", 3'd1, DASH, DASH, DASH);

        // ch0: 580 us -> 10 cm.
        expect_res(0, 10, 1'b0);
        run_ping(1'b0, 2320, 0, tf);
        wait_valid("p3", 200, at);
        check_disp("p3_disp", 3'd0, S0, S1, S0);

        // ch1: 57 us -> 0 cm.
        expect_res(1, 0, 1'b0);
        run_ping(1'b1, 228, 0, tf);
        wait_valid("p4", 200, at);
        check_disp("p4_disp", 3'd1, S0, S0, S0);

        // ch0: 58 us -> 1 cm; out-of-range selector reads channel 0.
        expect_res(0, 1, 1'b0);
        run_ping(1'b0, 232, 0, tf);
        wait_valid("p5", 200, at);
        check_disp("p5_disp", 3'd0, S0, S0, S1);
        check_disp("p5_disp_sel5", 3'd5, S0, S0, S1);

        // ch1: 406 us -> 7 cm, shown without leading-zero blanking.
        expect_res(1, 7, 1'b0);
        run_ping(1'b1, 1624, 0, tf);
        wait_valid("p6", 200, at);
        check_disp("p6_disp", 3'd1, S0, S0, S7);

        // ch0: on_off dropped mid-echo; ping completes, one holdoff, then idle.
        expect_res(0, 10, 1'b0);
        run_ping(1'b0, 2320, 2, tf);
        wait_valid("p7", 200, at);
        check("p7_busy_holdoff", 32'(busy), 32'd1);
        repeat (450) @(negedge clk);
        check("p7_busy_idle", 32'(busy), 32'd0);
        seen = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (trig != 2'b00) seen = 1'b1;
        end
        check("p7_no_trig_after_off", 32'(seen), 32'd0);

        // Reset during ch1's trigger pulse.
        on_off = 1'b1;
        wait_trig(1'b1, 100, seen);
        repeat (5) @(negedge clk);
        rst    = 1'b1;
        on_off = 1'b0;
        @(negedge clk);
        check("mid_rst_trig", 32'(trig), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_ch", 32'(dist_ch), 32'd0);
        check("mid_rst_cm", 32'(dist_cm), 32'd0);
        check("mid_rst_timeout", 32'(dist_timeout), 32'd0);
        check_disp("mid_rst_disp0", 3'd0, S0, S0, S0);
        check_disp("mid_rst_disp1", 3'd1, S0, S0, S0);
        @(negedge clk);
        rst    = 1'b0;
        on_off = 1'b1;

        // After reset the next ping must be on channel 0.
        expect_res(0, 20, 1'b1);
        run_ping(1'b0, 0, 1, tf);
        wait_valid("p9", 3000, at);
        check("p9_timeout_latency", 32'(at - tf), 32'd2000);
        repeat (450) @(negedge clk);
        check("p9_busy_idle", 32'(busy), 32'd0);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ultrasonic_ranger_mc.md
ULTRASONIC_RANGER_MC -- requirements
Module: ultrasonic_ranger_mc

Interface
REQ-001 Parameter CLK_HZ, default 50_000_000, clock frequency; CLK_HZ/1_000_000 (US_TICKS) SHALL be an integer >= 2.
REQ-002 Parameter N_CH, default 2, number of sensors, 1..8.
REQ-003 Parameter TRIG_US, default 10, trigger pulse width in us.
REQ-004 Parameter TIMEOUT_US, default 38000, maximum wait for echo rise after trigger fall.
REQ-005 Parameter HOLDOFF_US, default 60000, quiet time between consecutive pings.
REQ-006 Parameter MAX_CM, default 400, range ceiling in cm, <= 511.
REQ-007 clk  in  1  system clock, all logic on rising edge.
REQ-008 rst  in  1  reset, synchronous, active-high.
REQ-009 on_off  in  1  ranging enable.
REQ-010 echo  in  N_CH  asynchronous sensor echo lines.
REQ-011 disp_sel  in  3  channel shown on display outputs, values >= N_CH read channel 0.
REQ-012 trig  out  N_CH  sensor trigger pulses, one-hot or zero.
REQ-013 dist_valid  out  1  one-cycle strobe, result fields valid.
REQ-014 dist_ch  out  3  channel of current result.
REQ-015 dist_cm  out  9  distance in cm.
REQ-016 dist_timeout  out  1  no echo or out of range.
REQ-017 busy  out  1  high in any state except IDLE.
REQ-018 ones, tens, hundreds  out  7 each  seven-segment codes, active-high, bit order gfedcba.

Function
REQ-019 Each echo bit SHALL pass a 2-flop synchroniser; all decisions use synchronised values.
REQ-020 A free-running us-tick divider SHALL pulse once every US_TICKS cycles; it restarts on every state entry.
REQ-021 FSM states: IDLE, TRIG, WAIT_RISE, MEASURE, HOLDOFF.
REQ-022 IDLE -> TRIG when on_off=1; on_off is sampled only in IDLE; deassertion mid-cycle completes the current ping, then stays IDLE.
REQ-023 TRIG: trig[ch]=1 for exactly TRIG_US*US_TICKS cycles, then WAIT_RISE.
REQ-024 WAIT_RISE: echo[ch] high -> MEASURE; TIMEOUT_US elapsed -> result with dist_cm=MAX_CM, dist_timeout=1, then HOLDOFF.
REQ-025 MEASURE: a 0..57 us sub-counter SHALL increment dist_cm and a 3-digit BCD counter once per 58 us of echo high (floor division, no divider).
REQ-026 MEASURE exit on echo fall: dist_valid strobes the next cycle with the count, dist_timeout=0.
REQ-027 MEASURE exit on count reaching MAX_CM while echo is high: dist_cm=MAX_CM, dist_timeout=1.
REQ-028 HOLDOFF: wait HOLDOFF_US, then advance ch to (ch+1) mod N_CH and go to IDLE.
REQ-029 Each result SHALL be stored per channel as BCD plus timeout flag; display outputs decode the stored entry for disp_sel.
REQ-030 Digit encodings: 0=0111111, 1=0000110, 2=1011011, 3=1001111, 4=1100110, 5=1101101, 6=1111101, 7=0000111, 8=1111111, 9=1101111; a timeout entry shows dash 1000000 on all three digits.
REQ-031 Leading-zero blanking SHALL be absent; 7 cm shows 0,0,7.

Reset
REQ-032 rst SHALL force IDLE, ch=0, trig=0, dist_valid=0, dist_ch=0, dist_cm=0, dist_timeout=0, busy=0, and clear all stored entries to 0 (display 000); it takes effect at the next clock edge, including mid-ping.
REQ-033 Synchroniser flops SHALL reset to 0.

Structure
REQ-034 The FSM state enum, the 58 us/cm constant, and the seven-segment codes SHALL live in the shared package ultrasonic_pkg.
REQ-035 Seven-segment decoding SHALL be a sub-module, seg7_decode (4-bit BCD plus blank/dash control in, 7-bit code out), instantiated three times.

Verification
Parameters for all scenarios: CLK_HZ=4_000_000, N_CH=2, TRIG_US=10, TIMEOUT_US=500, HOLDOFF_US=100, MAX_CM=20.
REQ-036 on_off=1, echo[0] high 40 cycles after trigger fall for 1160 us -> trig[0] high exactly 40 cycles; dist_valid with ch=0, cm=20? No: 1160/58=20=MAX_CM -> timeout=1; repeat with 580 us -> cm=10, timeout=0, display 0,1,0.
REQ-037 No echo on ch1 -> dist_valid 2000 cycles after trig fall with cm=20, timeout=1; hundreds/tens/ones show dash with disp_sel=1.
REQ-038 Echo high for 57 us -> cm=0; echo high for 58 us -> cm=1.
REQ-039 on_off dropped during MEASURE -> result still reported, one HOLDOFF follows, then IDLE with busy=0 and no further trig.
REQ-040 rst asserted during TRIG -> trig=0 and busy=0 at the next edge, ch=0, display 000.
